voice_mixer: RTL and testbench

Sample-synchronous mixer between the eight `Voice` outputs and the output `filter`. It replaces the plain wrap-around 16-bit sum. Once per codec left/right clock period it snapshots all voice samples and accumulates the enabled voices serially at full precision. It then applies a master gain, saturates to signed 16 bits, and presents one sample with a valid strobe to the filter stage.

---
 rtl/voice_mixer.sv | 137 +++++++++++++
 tb/tb_voice_mixer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_mixer.sv
// voice_mixer: once per codec LR period, snapshot all voice samples, sum the
// enabled voices serially at full precision, apply a Q1.8 master gain and
// saturate to a signed W-bit sample presented with a one-cycle valid strobe.
module voice_mixer #(
    parameter int NUM_VOICES = 8,
    parameter int W          = 16
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    lrck,
    input  logic [NUM_VOICES*W-1:0] voice_in,
    input  logic [NUM_VOICES-1:0]   voice_en,
    input  logic [8:0]              gain,
    input  logic                    clip_clr,
    output logic signed [W-1:0]     mix_out,
    output logic                    mix_valid,
    output logic                    busy,
    output logic                    clip
);
    localparam int IDX_W  = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    // Three guard bits: eight full-scale voices can never wrap the sum.
    localparam int ACC_W  = W + 3;
    // Accumulator times a 10-bit signed (zero-extended 9-bit) gain.
    localparam int PROD_W = ACC_W + 10;
    // Product after dropping the 8 fractional gain bits.
    localparam int SC_W   = PROD_W - 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

    typedef enum logic [1:0] {IDLE, ACCUM, SCALE, OUT} state_t;

    state_t                   state;
    logic                     s1, s2, s3;
    logic                     lrck_rise;
    logic signed [W-1:0]      snap_voice [NUM_VOICES];
    logic [NUM_VOICES-1:0]    snap_en;
    logic signed [ACC_W-1:0]  acc;
    logic [IDX_W-1:0]         idx;
    logic                     sat_flag;
    logic signed [ACC_W-1:0]  voice_term;
    logic signed [PROD_W-1:0] prod;
    logic signed [SC_W-1:0]   scaled;
    logic signed [W-1:0]      sat_val;
    logic                     sat_over;

    // Clamp a scaled value into the signed W-bit range.
    function automatic logic signed [W-1:0] saturate(input logic signed [SC_W-1:0] v);
        logic [SC_W-W:0] top;
        top = v[SC_W-1:W-1];
        if (top == '0 || top == '1)
            return v[W-1:0];
        else if (v[SC_W-1])
            return {1'b1, {(W-1){1'b0}}};
        else
            return {1'b0, {(W-1){1'b1}}};
    endfunction

    assign lrck_rise = s2 & ~s3;
    assign busy      = (state != IDLE);

    // Two-flop synchronizer for the asynchronous lrck plus one delay for edge detect.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= lrck;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // Snapshot of all voices and enables at the start of a mix; data only, no reset.
    always_ff @(posedge Clk) begin
        if (state == IDLE && lrck_rise) begin
            for (int i = 0; i < NUM_VOICES; i++)
                snap_voice[i] <= voice_in[i*W +: W];
            snap_en <= voice_en;
        end
    end

    // Current accumulate term, gain product, truncating shift and saturation.
    always_comb begin
        voice_term = snap_en[idx] ? {{(ACC_W-W){snap_voice[idx][W-1]}}, snap_voice[idx]} : '0;
        prod       = PROD_W'(acc) * PROD_W'($signed({1'b0, gain}));
        scaled     = SC_W'(prod >>> 8);
        sat_val    = saturate(scaled);
        sat_over   = (scaled != {{(SC_W-W){sat_val[W-1]}}, sat_val});
    end

    // Mix sequencer: IDLE -> ACCUM (one voice per cycle) -> SCALE -> OUT.
    // mix_out is loaded leaving SCALE so it already holds the new sample
    // during the OUT cycle, where mix_valid is high.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state     <= IDLE;
            acc       <= '0;
            idx       <= '0;
            mix_out   <= '0;
            mix_valid <= 1'b0;
            sat_flag  <= 1'b0;
            clip      <= 1'b0;
        end else begin
            mix_valid <= 1'b0;
            if (clip_clr)
                clip <= 1'b0;
            case (state)
                IDLE: begin
                    if (lrck_rise) begin
                        acc   <= '0;
                        idx   <= '0;
                        state <= ACCUM;
                    end
                end
                ACCUM: begin
                    acc <= acc + voice_term;
                    idx <= idx + IDX_W'(1);
                    if (idx == LAST_IDX)
                        state <= SCALE;
                end
                SCALE: begin
                    mix_out   <= sat_val;
                    sat_flag  <= sat_over;
                    mix_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    // A saturating sample overrides a simultaneous clear.
                    if (sat_flag)
                        clip <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_voice_mixer.sv
// Testbench for voice_mixer: scoreboard of expected mix samples popped on
// every mix_valid, plus per-scenario checks of clip, busy, latency and reset.
module tb_voice_mixer;
    localparam int NV = 8;
    localparam int W  = 16;

    logic                 Clk      = 1'b0;
    logic                 Reset_n  = 1'b0;
    logic                 lrck     = 1'b0;
    logic                 clip_clr = 1'b0;
    logic [NV*W-1:0]      voice_in = '0;
    logic [NV-1:0]        voice_en = '0;
    logic [8:0]           gain     = 9'd256;
    logic signed [W-1:0]  mix_out;
    logic                 mix_valid;
    logic                 busy;
    logic                 clip;

    int                   checks = 0;
    int                   errors = 0;
    logic [W-1:0]         exp_q[$];
    logic [W-1:0]         mon_exp;

    always #5 Clk = ~Clk;

    voice_mixer #(.NUM_VOICES(NV), .W(W)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .lrck      (lrck),
        .voice_in  (voice_in),
        .voice_en  (voice_en),
        .gain      (gain),
        .clip_clr  (clip_clr),
        .mix_out   (mix_out),
        .mix_valid (mix_valid),
        .busy      (busy),
        .clip      (clip)
    );

    function automatic logic [NV*W-1:0] fill(input logic [W-1:0] v);
        logic [NV*W-1:0] r;
        for (int i = 0; i < NV; i++) r[i*W +: W] = v;
        return r;
    endfunction

    // Scoreboard: every output strobe must match the oldest expected sample.
    always @(negedge Clk) begin
        if (mix_valid === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_valid mix_out=%h required no output", mix_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mix_out !== mon_exp) begin
                    errors++;
                    $display("FAIL mix_out got=%h exp=%h", mix_out, mon_exp);
                end
            end
        end
    end

    // One complete mix: set inputs, raise lrck, wait for the strobe.
    task automatic mix_once(input logic [NV*W-1:0] vin, input logic [NV-1:0] en,
                            input logic [8:0] g, input logic [W-1:0] expv, input bit clr_at_out);
        int n;
        voice_in = vin;
        voice_en = en;
        gain     = g;
        exp_q.push_back(expv);
        @(posedge Clk); #1 lrck = 1'b1;
        @(posedge Clk); #1;
        n = 1;
        while (mix_valid !== 1'b1 && n < 30) begin
            @(posedge Clk); #1;
            n++;
        end
        if (mix_valid !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL mix_timeout got no mix_valid exp within 30 cycles");
            exp_q.delete();
        end else if (clr_at_out) begin
            clip_clr = 1'b1;
        end
        @(posedge Clk); #1;
        clip_clr = 1'b0;
        lrck     = 1'b0;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(posedge Clk); #1;
            lrck = ~lrck;
            checks++;
            if ({mix_out, mix_valid, busy, clip} !== {16'h0000, 3'b000}) begin
                errors++;
                $display("FAIL reset_outputs got mix_out=%h valid=%b busy=%b clip=%b exp all 0",
                         mix_out, mix_valid, busy, clip);
            end
        end
        lrck    = 1'b0;
        Reset_n = 1'b1;
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic test_unity_latency();
        logic [12:0] vpat;
        logic [12:0] bpat;
        voice_in = fill(16'h0800);
        voice_en = 8'hFF;
        gain     = 9'd256;
        exp_q.push_back(16'h4000);
        vpat = '0;
        bpat = '0;
        @(posedge Clk); #1 lrck = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge Clk); #1;
            vpat[k-1] = mix_valid;
            bpat[k-1] = busy;
        end
        lrck = 1'b0;
        checks++;
        if (vpat !== 13'b0_1000_0000_0000) begin
            errors++;
            $display("FAIL valid_timing got=%b exp=%b", vpat, 13'b0_1000_0000_0000);
        end
        checks++;
        if (bpat !== 13'b0_1111_1111_1100) begin
            errors++;
            $display("FAIL busy_timing got=%b exp=%b", bpat, 13'b0_1111_1111_1100);
        end
        repeat (4) @(posedge Clk);
        #1;
        checks++;
        if (clip !== 1'b0) begin
            errors++;
            $display("FAIL unity_clip got=%b exp=0", clip);
        end
    endtask

    task automatic test_saturation();
        mix_once(fill(16'h8000), 8'hFF, 9'd256, 16'h8000, 1'b0);
        checks++;
        if (clip !== 1'b1) begin
            errors++;
            $display("FAIL clip_neg got=%b exp=1", clip);
        end
        mix_once(fill(16'h7FFF), 8'hFF, 9'd256, 16'h7FFF, 1'b0);
        clip_clr = 1'b1;
        @(posedge Clk); #1 clip_clr = 1'b0;
        checks++;
        if (clip !== 1'b0) begin
            errors++;
            $display("FAIL clip_clear got=%b exp=0", clip);
        end
        mix_once(fill(16'h8000), 8'hFF, 9'd256, 16'h8000, 1'b1);
        checks++;
        if (clip !== 1'b1) begin
            errors++;
            $display("FAIL clip_set_wins got=%b exp=1", clip);
        end
    endtask

    task automatic test_mask();
        logic [NV*W-1:0] v;
        clip_clr = 1'b1;
        @(posedge Clk); #1 clip_clr = 1'b0;
        v = fill(16'h7FFF);
        v[W-1:0] = 16'h1234;
        mix_once(v, 8'h01, 9'd256, 16'h1234, 1'b0);
        checks++;
        if (clip !== 1'b0) begin
            errors++;
            $display("FAIL mask_clip got=%b exp=0", clip);
        end
    endtask

    task automatic test_gain();
        logic [NV*W-1:0] v;
        mix_once(fill(16'h0100), 8'hFF, 9'd128, 16'h0400, 1'b0);
        mix_once(fill(16'h0100), 8'hFF, 9'd0,   16'h0000, 1'b0);
        mix_once(fill(16'h0100), 8'hFF, 9'd511, 16'h0FF8, 1'b0);
        v = fill(16'h0100);
        v[W-1:0] = 16'hFFFF;
        mix_once(v, 8'h01, 9'd128, 16'hFFFF, 1'b0);
    endtask

    task automatic test_snapshot_overlap();
        int nv;
        voice_in = fill(16'h0100);
        voice_en = 8'hFF;
        gain     = 9'd256;
        exp_q.push_back(16'h0800);
        nv = 0;
        @(posedge Clk); #1 lrck = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            @(posedge Clk); #1;
            if (k == 4) lrck = 1'b0;
            if (k == 5) begin
                voice_in = fill(16'h7FFF);
                voice_en = 8'h0F;
                lrck     = 1'b1;
            end
            if (mix_valid === 1'b1) nv++;
        end
        lrck = 1'b0;
        checks++;
        if (nv !== 1) begin
            errors++;
            $display("FAIL overlap_valid_count got=%0d exp=1", nv);
        end
        repeat (4) @(posedge Clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int nv;
        voice_in = fill(16'h0200);
        voice_en = 8'hFF;
        gain     = 9'd256;
        @(posedge Clk); #1 lrck = 1'b1;
        repeat (6) @(posedge Clk);
        #1;
        Reset_n = 1'b0;
        lrck    = 1'b0;
        @(posedge Clk); #1 Reset_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || mix_out !== 16'h0000) begin
            errors++;
            $display("FAIL midreset_state got busy=%b mix_out=%h exp busy=0 mix_out=0000", busy, mix_out);
        end
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge Clk); #1;
            if (mix_valid === 1'b1) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL midreset_valid_count got=%0d exp=0", nv);
        end
        mix_once(fill(16'h0010), 8'hFF, 9'd256, 16'h0080, 1'b0);
    endtask

    initial begin
        test_reset();
        test_unity_latency();
        test_saturation();
        test_mask();
        test_gain();
        test_snapshot_overlap();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got=%0d pending exp=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
